// File: rtl/raddr_pkg.sv
// Shared encodings and AXI field widths for the read-address arbiter.
package raddr_pkg;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'h1,
    SEND = 2'h2
  } state_t;
endpackage

// File: rtl/raddr_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible index at or after ptr, wrapping at N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] win
);
  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
endmodule

// File: rtl/raddr_arbiter.sv
// Round-robin sharing of one AXI AR channel; arid carries the requester index and
// per-requester outstanding bursts are tracked by snooping rlast.
module raddr_arbiter
  import raddr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [LEN_W-1:0]          m_axi_arlen,
  output logic [ID_W-1:0]           m_axi_arid,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_W-1:0]           m_axi_rid,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  input  logic                      m_axi_rready,
  output logic                      busy,
  output logic                      err_underflow
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  state_t                            state, nxt;
  logic                              load, hs, found, r_done;
  logic [IDX_W-1:0]                  win, grant, ptr;
  logic [NUM_REQ-1:0]                elig, uf;
  logic [NUM_REQ-1:0][CNT_W-1:0]     out_cnt;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_v;
  logic [NUM_REQ-1:0][LEN_W-1:0]     len_v;

  assign addr_v = req_araddr;
  assign len_v  = req_arlen;

  assign hs     = (state == SEND) && m_axi_arready;
  assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (elig),
    .ptr      (ptr),
    .found    (found),
    .win      (win)
  );

  // Per-requester outstanding counter; simultaneous inc/dec cancel.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic             inc, dec;
    logic [CNT_W-1:0] cnt_q;

    assign inc        = hs && (grant == IDX_W'(i));
    assign dec        = r_done && (m_axi_rid == ID_W'(i));
    assign uf[i]      = dec && !inc && (cnt_q == '0);
    assign elig[i]    = req_arvalid[i] && (cnt_q < CNT_W'(MAX_OUT));
    assign out_cnt[i] = cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n)                             cnt_q <= '0;
      else if (inc && !dec)                   cnt_q <= cnt_q + 1'b1;
      else if (dec && !inc && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE: if (enable && found) begin
        nxt  = SEND;
        load = 1'b1;
      end
      SEND: if (m_axi_arready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      ptr           <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        grant        <= win;
        m_axi_araddr <= addr_v[win];
        m_axi_arlen  <= len_v[win];
      end
      if (hs) ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      if (|uf) err_underflow <= 1'b1;
    end
  end

  assign m_axi_arvalid = (state == SEND);
  assign m_axi_arid    = ID_W'(grant);
  assign req_arready   = hs ? (NUM_REQ'(1) << grant) : '0;
  assign busy          = (state != IDLE) || (|out_cnt);
endmodule

// File: tb/tb_raddr_arbiter.sv
// Randomized + directed bench for raddr_arbiter against a transaction-level model.
module tb_raddr_arbiter;
  localparam int N = 4, ID_W = 3, MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst_n, enable;
  logic [N*64-1:0]   req_araddr;
  logic [N*8-1:0]    req_arlen;
  logic [N-1:0]      req_arvalid, req_arready;
  logic [63:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [ID_W-1:0]   m_axi_arid, m_axi_rid;
  logic              m_axi_arvalid, m_axi_arready;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic              busy, err_underflow;

  always #5 clk = ~clk;

  raddr_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .busy(busy), .err_underflow(err_underflow)
  );

  int tests = 0, fails = 0;

  // Model: one pending AR (or none), a priority pointer and per-id outstanding counts.
  bit          m_act, m_err;
  int          m_idx, m_ptr, acc;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int          mcnt[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_err = 1'b0; m_idx = 0; m_ptr = 0; m_addr = '0; m_len = '0; acc = -1;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
  endtask

  task automatic compare();
    logic [N-1:0] exp_rdy;
    bit           exp_busy;
    exp_rdy  = '0;
    exp_busy = m_act;
    for (int i = 0; i < N; i++) begin
      if (m_act && m_axi_arready && m_idx == i) exp_rdy[i] = 1'b1;
      if (mcnt[i] != 0) exp_busy = 1'b1;
      check("out_cnt", 64'(dut.out_cnt[i]), 64'(mcnt[i]));
    end
    check("arvalid", 64'(m_axi_arvalid), 64'(m_act));
    check("arid", 64'(m_axi_arid), 64'(m_idx));
    check("araddr", m_axi_araddr, m_addr);
    check("arlen", 64'(m_axi_arlen), 64'(m_len));
    check("req_arready", 64'(req_arready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(exp_busy));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic step();
    bit rdone, inc, dec;
    int rid_i, c;
    acc = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdone = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    rid_i = int'(m_axi_rid);
    if (m_act) begin
      if (m_axi_arready) begin
        acc   = m_idx;
        m_act = 1'b0;
        m_ptr = (m_idx + 1) % N;
      end
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (req_arvalid[c] && mcnt[c] < MAX_OUT) begin
          m_act  = 1'b1;
          m_idx  = c;
          m_addr = req_araddr[c*64 +: 64];
          m_len  = req_arlen[c*8 +: 8];
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      inc = (acc == i);
      dec = rdone && (rid_i == i);
      if (inc && !dec) mcnt[i]++;
      else if (dec && !inc) begin
        if (mcnt[i] == 0) m_err = 1'b1;
        else mcnt[i]--;
      end
    end
  endtask

  // Called at a negedge with inputs set; compares, takes the edge, returns at next negedge.
  task automatic cycle();
    #1 compare();
    @(posedge clk);
    step();
    @(negedge clk);
    if (acc >= 0) req_arvalid[acc] = 1'b0;
  endtask

  task automatic clear_r();
    m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0; m_axi_rid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_arvalid = '0; clear_r();
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; enable = 1'b1; req_araddr = '0; req_arlen = '0; req_arvalid = '0;
    m_axi_arready = 1'b0; clear_r();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    check("rst_rdy", 64'(req_arready), 64'd0);

    // Single request from requester 2
    req_araddr[2*64 +: 64] = 64'h1000; req_arlen[2*8 +: 8] = 8'd2;
    req_arvalid = 4'b0100; m_axi_arready = 1'b1;
    cycle();
    #1;
    check("single_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("single_arid", 64'(m_axi_arid), 64'd2);
    check("single_araddr", m_axi_araddr, 64'h1000);
    check("single_arlen", 64'(m_axi_arlen), 64'd2);
    check("single_rdy", 64'(req_arready), 64'b0100);
    cycle();
    check("single_cnt2", 64'(dut.out_cnt[2]), 64'd1);

    // All requesting continuously: grants 0,1,2,3,0 two cycles apart
    do_reset();
    for (int i = 0; i < N; i++) req_araddr[i*64 +: 64] = 64'(32'h100 * i);
    for (int j = 0; j < 10; j++) begin
      req_arvalid = '1;
      cycle();
      check("rr_acc", 64'(acc), (j % 2 == 1) ? 64'(exp_g[j/2]) : 64'(-1));
    end

    // Throttle requester 1 at MAX_OUT, serve 3, then release via rlast
    do_reset();
    for (int j = 0; j < 10; j++) begin
      req_arvalid[1] = 1'b1;
      cycle();
    end
    #1;
    check("thr_cnt1", 64'(dut.out_cnt[1]), 64'd4);
    check("thr_withheld", 64'(m_axi_arvalid), 64'd0);
    req_arvalid = 4'b1010;
    cycle();
    check("thr_other_arid", 64'(m_axi_arid), 64'd3);
    check("thr_other_vld", 64'(m_axi_arvalid), 64'd1);
    cycle();
    m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 3'd1;
    cycle();
    clear_r();
    cycle();
    check("thr_rel_arid", 64'(m_axi_arid), 64'd1);
    check("thr_rel_vld", 64'(m_axi_arvalid), 64'd1);
    cycle();

    // arready held low for 5 cycles
    do_reset();
    req_araddr[0 +: 64] = 64'hDEAD_BEEF_0000_0040; req_arlen[0 +: 8] = 8'd7;
    req_arvalid = 4'b0001; m_axi_arready = 1'b0;
    cycle();
    req_arvalid[3] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("hold_vld", 64'(m_axi_arvalid), 64'd1);
      check("hold_addr", m_axi_araddr, 64'hDEAD_BEEF_0000_0040);
      check("hold_len", 64'(m_axi_arlen), 64'd7);
      check("hold_id", 64'(m_axi_arid), 64'd0);
      check("hold_rdy", 64'(req_arready), 64'd0);
      cycle();
    end
    m_axi_arready = 1'b1;
    cycle();
    req_arvalid = '0;

    // Same-cycle handshake and rlast for id 0 at count 3
    do_reset();
    for (int j = 0; j < 7; j++) begin
      req_arvalid[0] = 1'b1;
      cycle();
    end
    check("same_pre", 64'(dut.out_cnt[0]), 64'd3);
    m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 3'd0;
    cycle();
    clear_r();
    check("same_cnt0", 64'(dut.out_cnt[0]), 64'd3);

    // Underflow: rlast id 0 at count 0
    do_reset();
    m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 3'd0;
    cycle();
    clear_r();
    check("uf_err", 64'(err_underflow), 64'd1);
    check("uf_cnt", 64'(dut.out_cnt[0]), 64'd0);
    repeat (3) cycle();
    check("uf_sticky", 64'(err_underflow), 64'd1);

    // Reset during SEND, with one burst outstanding
    do_reset();
    check("uf_cleared", 64'(err_underflow), 64'd0);
    req_arvalid = 4'b0010; m_axi_arready = 1'b1;
    cycle(); cycle();
    req_arvalid = 4'b0100; m_axi_arready = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    #1;
    check("rs_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_cnt1", 64'(dut.out_cnt[1]), 64'd0);
    rst_n = 1'b1; req_arvalid = '0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 599) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      m_axi_arready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_arvalid[i] && $urandom_range(0, 2) == 0) begin
          req_araddr[i*64 +: 64] = {$urandom(), $urandom()};
          req_arlen[i*8 +: 8]    = 8'($urandom());
          req_arvalid[i]         = 1'b1;
        end
      end
      m_axi_rvalid = 1'($urandom_range(0, 1));
      m_axi_rready = 1'($urandom_range(0, 1));
      m_axi_rlast  = ($urandom_range(0, 2) == 0);
      m_axi_rid    = ID_W'($urandom_range(0, 7));
      if (int'(m_axi_rid) < N && mcnt[int'(m_axi_rid)] == 0) m_axi_rlast = 1'b0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
